// File: rtl/pe_pkg.sv
// Shared processing-element definitions: operand widths and the accumulator state encoding.
// The square-root stage consumes PE_ACC_W-wide radicands produced by pe_sumsq_accum.
// No logic here; types and constants only.
package pe_pkg;

  localparam int PE_ACC_W  = 64;
  localparam int PE_DATA_W = 32;
  localparam int PE_CNT_W  = 16;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } pe_state_e;

endpackage

// File: rtl/pe_sumsq_accum_if.sv
// Stream bundle for the sum-of-squares accumulator: element input and result output.
// master = element producer / result consumer, slave = the accumulator.
// Both directions use valid/ready.
interface pe_sumsq_accum_if
  import pe_pkg::*;
#(
  parameter int DATA_W = PE_DATA_W,
  parameter int ACC_W  = PE_ACC_W,
  parameter int CNT_W  = PE_CNT_W
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_count;
  logic              out_sat;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_sat
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_sat
  );

endinterface

// File: rtl/pe_sat_add.sv
// Unsigned W-bit adder that clamps to all ones on carry-out and flags the overflow.
// Purely combinational, zero latency.
// No flow control.
module pe_sat_add
  import pe_pkg::*;
#(
  parameter int W = PE_ACC_W
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic         ovf_o
);

  logic [W:0] raw;

  assign raw   = {1'b0, a_i} + {1'b0, b_i};
  assign ovf_o = raw[W];
  assign sum_o = raw[W] ? {W{1'b1}} : raw[W-1:0];

endmodule

// File: rtl/pe_sumsq_accum.sv
// Streaming sum of squares with saturation; feeds the radicand to the square-root stage.
// One element per cycle; result valid the cycle after the last element is accepted.
// Input stalls (in_ready=0) while a result is held; in_ready depends on state only.
module pe_sumsq_accum
  import pe_pkg::*;
#(
  parameter int DATA_W = PE_DATA_W,
  parameter int ACC_W  = PE_ACC_W,  // must be at least 2*DATA_W
  parameter int CNT_W  = PE_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  pe_sumsq_accum_if.slave    bus
);

  pe_state_e        state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  logic [2*DATA_W-1:0] din_ext;
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    sq;
  logic [ACC_W-1:0]    acc_sum;
  logic                acc_ovf;
  logic                in_fire;
  logic                out_fire;

  // Sign-extend to 2*DATA_W so the low 2*DATA_W bits of the product are the exact
  // square; the most negative input squares to 2^(2*DATA_W-2) without wrapping.
  assign din_ext = {{DATA_W{bus.in_data[DATA_W-1]}}, bus.in_data};
  assign prod    = din_ext * din_ext;
  assign sq      = ACC_W'(prod);

  pe_sat_add #(.W(ACC_W)) u_sat_add (
    .a_i   (acc_q),
    .b_i   (sq),
    .sum_o (acc_sum),
    .ovf_o (acc_ovf)
  );

  assign in_fire  = bus.in_valid && (state_q == ACCUM);
  assign out_fire = bus.out_ready && (state_q == HOLD);

  // Next-state and accumulator update: accumulate in ACCUM, clear on output handshake.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    case (state_q)
      ACCUM: begin
        if (in_fire) begin
          acc_d = acc_sum;
          sat_d = sat_q | acc_ovf;
          cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
          if (bus.in_last) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_fire) begin
          acc_d   = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State and accumulator registers; reset discards any partial or held result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_sum   = acc_q;
  assign bus.out_count = cnt_q;
  assign bus.out_sat   = sat_q;

endmodule

// File: tb/tb_pe_sumsq_accum.sv
// Scoreboard bench for pe_sumsq_accum: expected results queued on stimulus, compared on output.
// Covers reset, basic vector, backpressure, saturation, zeros, back-to-back and reset cases.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_pe_sumsq_accum;
  import pe_pkg::*;

  typedef struct packed {
    logic [63:0] sum;
    logic [15:0] cnt;
    logic        sat;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  pe_sumsq_accum_if #(.DATA_W(PE_DATA_W), .ACC_W(PE_ACC_W), .CNT_W(PE_CNT_W)) bus ();

  pe_sumsq_accum #(.DATA_W(PE_DATA_W), .ACC_W(PE_ACC_W), .CNT_W(PE_CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  res_t sb[$];
  logic signed [31:0] vec[$];

  logic [63:0] m_acc;
  logic [15:0] m_cnt;
  logic        m_sat;

  task automatic model_reset();
    m_acc = '0;
    m_cnt = '0;
    m_sat = 1'b0;
  endtask

  // Reference accumulation: exact square, 65-bit add, clamp on carry.
  task automatic model_accept(input logic signed [31:0] d, input logic last);
    longint      sd;
    logic [63:0] sq;
    logic [64:0] t;
    res_t        r;
    sd = d;
    sq = sd * sd;
    t  = {1'b0, m_acc} + {1'b0, sq};
    if (t[64]) begin
      m_acc = '1;
      m_sat = 1'b1;
    end else begin
      m_acc = t[63:0];
    end
    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    if (last) begin
      r.sum = m_acc;
      r.cnt = m_cnt;
      r.sat = m_sat;
      sb.push_back(r);
      model_reset();
    end
  endtask

  // Push the elements of vec back to back; the last one carries in_last when with_last.
  task automatic send_vec(input bit with_last);
    int guard;
    for (int i = 0; i < vec.size(); i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = vec[i];
      bus.in_last  = with_last && (i == vec.size() - 1);
      guard = 0;
      while (!bus.in_ready && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      if (!bus.in_ready) begin
        n_cmp++;
        n_fail++;
        $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, guard);
      end else begin
        model_accept(vec[i], bus.in_last);
      end
      @(posedge clk);
    end
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic release_out();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    model_reset();
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_sum !== 64'd0) begin n_fail++; $display("FAIL reset_out_sum: got %0d want 0", bus.out_sum); end
    n_cmp++; if (bus.out_count !== 16'd0) begin n_fail++; $display("FAIL reset_out_count: got %0d want 0", bus.out_count); end
    n_cmp++; if (bus.out_sat !== 1'b0) begin n_fail++; $display("FAIL reset_out_sat: got %b want 0", bus.out_sat); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic(output res_t held);
    res_t exp, obs;
    vec = '{3, -4, 12};
    send_vec(1'b1);
    @(negedge clk);
    exp = (sb.size() > 0) ? sb.pop_front() : '0;
    obs = {bus.out_sum, bus.out_count, bus.out_sat};
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || obs !== exp || exp.sum !== 64'd169) begin
      n_fail++;
      $display("FAIL basic: valid=%b ready=%b sum=%0d cnt=%0d sat=%b want valid=1 ready=0 sum=%0d cnt=%0d sat=%b",
               bus.out_valid, bus.in_ready, obs.sum, obs.cnt, obs.sat, exp.sum, exp.cnt, exp.sat);
    end
    held = exp;
  endtask

  task automatic test_backpressure(input res_t held);
    res_t exp, obs;
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = $urandom;
      bus.in_last  = $urandom_range(0, 1);
      @(negedge clk);
      obs = {bus.out_sum, bus.out_count, bus.out_sat};
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || obs !== held) begin
        n_fail++;
        $display("FAIL hold_stable[%0d]: valid=%b ready=%b sum=%0d cnt=%0d want valid=1 ready=0 sum=%0d cnt=%0d",
                 c, bus.out_valid, bus.in_ready, obs.sum, obs.cnt, held.sum, held.cnt);
      end
    end
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_sum !== 64'd0 || bus.out_count !== 16'd0) begin
      n_fail++;
      $display("FAIL after_handshake: valid=%b ready=%b sum=%0d cnt=%0d want 0 1 0 0",
               bus.out_valid, bus.in_ready, bus.out_sum, bus.out_count);
    end
    vec = '{7};
    send_vec(1'b1);
    @(negedge clk);
    exp = (sb.size() > 0) ? sb.pop_front() : '0;
    obs = {bus.out_sum, bus.out_count, bus.out_sat};
    n_cmp++;
    if (bus.out_valid !== 1'b1 || obs !== exp || obs.sum !== 64'd49 || obs.cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL seven: valid=%b sum=%0d cnt=%0d sat=%b want sum=49 cnt=1 sat=0",
               bus.out_valid, obs.sum, obs.cnt, obs.sat);
    end
    release_out();
  endtask

  task automatic test_saturation();
    res_t exp, obs;
    vec = '{32'sh8000_0000, 32'sh8000_0000, 32'sh8000_0000, 32'sh8000_0000, 32'sh8000_0000};
    send_vec(1'b1);
    @(negedge clk);
    exp = (sb.size() > 0) ? sb.pop_front() : '0;
    obs = {bus.out_sum, bus.out_count, bus.out_sat};
    n_cmp++;
    if (bus.out_valid !== 1'b1 || obs !== exp || obs.sum !== 64'hFFFF_FFFF_FFFF_FFFF || obs.sat !== 1'b1 || obs.cnt !== 16'd5) begin
      n_fail++;
      $display("FAIL saturation: valid=%b sum=%h cnt=%0d sat=%b want sum=%h cnt=5 sat=1",
               bus.out_valid, obs.sum, obs.cnt, obs.sat, exp.sum);
    end
    release_out();
  endtask

  task automatic test_zero_and_back_to_back();
    res_t exp, obs;
    logic signed [31:0] vals[5];
    logic lasts[5];
    int k, cyc, last_acc;
    bit prev_last;
    vals  = '{1, 2, 3, 0, -5};
    lasts = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vec = '{0};
    send_vec(1'b1);
    @(negedge clk);
    exp = (sb.size() > 0) ? sb.pop_front() : '0;
    obs = {bus.out_sum, bus.out_count, bus.out_sat};
    n_cmp++;
    if (bus.out_valid !== 1'b1 || obs !== exp || obs.sum !== 64'd0 || obs.cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL zero: valid=%b sum=%0d cnt=%0d want sum=0 cnt=1", bus.out_valid, obs.sum, obs.cnt);
    end
    release_out();

    bus.out_ready = 1'b1;
    k = 0; cyc = 0; last_acc = -10; prev_last = 1'b0;
    while (k < 5 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.out_valid) begin
        exp = (sb.size() > 0) ? sb.pop_front() : '0;
        obs = {bus.out_sum, bus.out_count, bus.out_sat};
        n_cmp++;
        if (obs !== exp) begin
          n_fail++;
          $display("FAIL b2b_result: sum=%0d cnt=%0d want sum=%0d cnt=%0d", obs.sum, obs.cnt, exp.sum, exp.cnt);
        end
      end
      bus.in_valid = 1'b1;
      bus.in_data  = vals[k];
      bus.in_last  = lasts[k];
      if (bus.in_ready) begin
        if (prev_last) begin
          n_cmp++;
          if (cyc - last_acc !== 2) begin
            n_fail++;
            $display("FAIL b2b_gap: %0d cycles between vectors, want 2", cyc - last_acc);
          end
        end
        model_accept(vals[k], lasts[k]);
        prev_last = lasts[k];
        last_acc  = cyc;
        k++;
      end
    end
    if (k < 5) begin
      n_cmp++;
      n_fail++;
      $display("FAIL b2b_timeout: accepted %0d elements, want 5", k);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    exp = (sb.size() > 0) ? sb.pop_front() : '0;
    obs = {bus.out_sum, bus.out_count, bus.out_sat};
    n_cmp++;
    if (bus.out_valid !== 1'b1 || obs !== exp || obs.sum !== 64'd25 || obs.cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL b2b_last: valid=%b sum=%0d cnt=%0d want sum=25 cnt=2", bus.out_valid, obs.sum, obs.cnt);
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    res_t exp, obs;
    vec = '{5, 5};
    send_vec(1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.out_sum !== 64'd0) begin
      n_fail++;
      $display("FAIL mid_reset: valid=%b sum=%0d want 0 0", bus.out_valid, bus.out_sum);
    end
    @(negedge clk);
    rst = 1'b0;
    vec = '{1};
    send_vec(1'b1);
    @(negedge clk);
    exp = (sb.size() > 0) ? sb.pop_front() : '0;
    obs = {bus.out_sum, bus.out_count, bus.out_sat};
    n_cmp++;
    if (bus.out_valid !== 1'b1 || obs !== exp || obs.sum !== 64'd1 || obs.cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL after_mid_reset: valid=%b sum=%0d cnt=%0d want sum=1 cnt=1", bus.out_valid, obs.sum, obs.cnt);
    end
    release_out();

    vec = '{9};
    send_vec(1'b1);
    @(negedge clk);
    exp = (sb.size() > 0) ? sb.pop_front() : '0;
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== exp.sum) begin
      n_fail++;
      $display("FAIL hold_before_reset: valid=%b sum=%0d want 1 %0d", bus.out_valid, bus.out_sum, exp.sum);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_sum !== 64'd0 || bus.out_count !== 16'd0) begin
      n_fail++;
      $display("FAIL hold_reset: valid=%b ready=%b sum=%0d cnt=%0d want 0 1 0 0",
               bus.out_valid, bus.in_ready, bus.out_sum, bus.out_count);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    res_t held;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    model_reset();
    test_reset();
    test_basic(held);
    test_backpressure(held);
    test_saturation();
    test_zero_and_back_to_back();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_sumsq_accum.md
# pe_sumsq_accum

Streaming sum-of-squares accumulator that sits directly upstream of the processing element's `squareroot` stage. It accepts a vector of signed integer elements over a valid/ready stream, squares each element, and accumulates the squares with saturation. On the last element it presents the 64-bit sum, which is the radicand for the square-root stage, plus an element count and a saturation flag through a valid/ready output.

## Interface
Parameters:
- `DATA_W`, default 32: width of each signed input element.
- `ACC_W`, default 64: accumulator and result width. Must be ≥ 2·`DATA_W`; it matches the 64-bit operand of `squareroot`.
- `CNT_W`, default 16: width of the element counter.

Ports. One clock; reset is asynchronous and active-high.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: an input element is present.
- `in_ready` out 1: the block can accept an element.
- `in_data` in `DATA_W`: the element, two's complement.
- `in_last` in 1: marks the final element of the vector.
- `out_valid` out 1: a result is held.
- `out_ready` in 1: downstream consumes the result.
- `out_sum` out `ACC_W`: the sum of squares, unsigned.
- `out_count` out `CNT_W`: number of elements accepted, saturating.
- `out_sat` out 1: the sum clamped at some point during the vector.

## Operation
- States: `ACCUM` (reset state) and `HOLD`.
- **ACCUM**
  - `in_ready`=1 and `out_valid`=0.
  - An element is accepted when `in_valid && in_ready`.
  - On accept:
    - `sq` = `in_data`·`in_data`, a signed product reinterpreted as unsigned 2·`DATA_W` bits and zero-extended to `ACC_W`.
    - `acc` ← sat(`acc` + `sq`). On carry-out, `acc` ← all ones and the sticky `sat` flag ← 1.
    - `cnt` ← `cnt`+1, stopping at all ones.
  - If the accepted element has `in_last`=1, go to `HOLD`.
- **HOLD**
  - `in_ready`=0 and `out_valid`=1.
  - `out_sum`=`acc`, `out_count`=`cnt`, `out_sat`=`sat`. These stay stable while `out_ready`=0.
  - On `out_valid && out_ready`: clear `acc`, `cnt` and `sat`, then go to `ACCUM`.
- A vector always has at least one element, because `in_last` travels with an element.
- Extremes with the defaults:
  - The most negative input (−2^31) squares to 2^62, with no intermediate overflow.
  - 0 squares to 0 and still increments `cnt`.
- `in_data` and `in_last` are ignored when `in_valid`=0.
- Reset values: state=`ACCUM`, `acc`=0, `cnt`=0, `sat`=0. Consequently `in_ready`=1, `out_valid`=0, `out_sum`=0, `out_count`=0, `out_sat`=0.
- Reset mid-vector discards the partial sum with no output.
- Reset in `HOLD` drops the pending result.

## Timing
- Single-cycle accumulate: an element accepted at edge N is reflected in `acc` after edge N.
- Latency: `out_valid` rises in the cycle after the edge that accepted the last element.
- `in_ready` is a pure function of state, with no combinational path from `out_ready`. Consequently:
  - At most one bubble cycle occurs between vectors: the handshake cycle in `HOLD`, followed by `ACCUM` on the next edge.
  - The first element of the next vector is accepted no earlier than the cycle after the output handshake.
- Throughput is one element per cycle within a vector.
- The output obeys valid/ready: once `out_valid`=1, it and all output data stay unchanged until the handshake.
- All outputs are registered or decoded from the state register.

## Structure
- Shared package `pe_pkg`: `PE_ACC_W`=64, `PE_DATA_W`=32, `PE_CNT_W`=16, and a state enum `{ACCUM, HOLD}`. The `squareroot` stage reuses `PE_ACC_W`.
- One sub-module, `pe_sat_add`: a combinational `ACC_W` unsigned adder with clamp-to-max and an overflow output. It is also reusable in the mean stage.
- The multiply is inferred inline.

## Test plan
- **Reset state:** assert `rst` asynchronously mid-cycle. Expect `in_ready`=1, `out_valid`=0 and all outputs 0 immediately, before the next edge.
- **Basic vector:** send 3, −4, 12 (last). One cycle after the last element: `out_valid`=1, `out_sum`=169, `out_count`=3, `out_sat`=0, with `in_ready`=0.
- **Backpressure:**
  - Hold `out_ready`=0 for 5 cycles after the basic vector. The outputs stay stable and `in_valid` is ignored.
  - Then pulse `out_ready`. The next vector, 7 (last), yields 49 with count 1.
- **Saturation:** send five elements of −2^31. The fourth push carries out (4·2^62 = 2^64), so the result is `out_sum`=2^64−1, `out_sat`=1, `out_count`=5.
- **Single element and zeros:** send 0 (last). Expect `out_sum`=0 and `out_count`=1. Then send back-to-back vectors with `out_ready` held at 1, and check there is exactly one bubble cycle between vectors.
- **Reset mid-operation:**
  - Send 5, 5, then assert `rst` without sending a last element. Then send 1 (last). Expect `out_sum`=1, `out_count`=1.
  - Separately, assert `rst` while in `HOLD`. `out_valid` must drop to 0.
